bus_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 22 ++
 rtl/timer_prescaler.sv | 35 +++
 rtl/bus_timer.sv | 155 +++++++++++++++
 tb/tb_bus_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// control-bit positions and the default bus width.
package timer_pkg;

  localparam int unsigned TIMER_DBITS = 32;

  localparam int unsigned OFS_CNT = 0;
  localparam int unsigned OFS_LIM = 4;
  localparam int unsigned OFS_CTL = 8;

  localparam int unsigned CTL_READY = 0;
  localparam int unsigned CTL_OVR   = 1;
  localparam int unsigned CTL_IE    = 8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_CNT,
    REG_LIM,
    REG_CTL
  } reg_sel_e;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: div counts 0..TICKDIV-1 and tick is high for the one cycle
// where div sits at TICKDIV-1; clr forces div back to 0.
module timer_prescaler #(
  parameter int unsigned DBITS   = 32,
  parameter int unsigned TICKDIV = 25000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [DBITS-1:0] DIV_LAST = DBITS'(TICKDIV - 1);

  logic [DBITS-1:0] div_q;
  logic [DBITS-1:0] div_d;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + DBITS'(1);
    if (clr || tick) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped interval timer (TCNT/TLIM/TCTL) with sticky ready/overrun flags.
// Define BUS_TIMER_INTR_EN to add the TCTL.IE bit and a registered interrupt.
module bus_timer
  import timer_pkg::*;
#(
  parameter int unsigned      DBITS   = TIMER_DBITS,
  parameter logic [DBITS-1:0] BASE    = DBITS'(32'hFFFFF100),
  parameter int unsigned      TICKDIV = 25000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  output logic [DBITS-1:0] rdata,
  output logic             sel,
  output logic             intr
);

  localparam logic [DBITS-1:0] ADDR_CNT = BASE + DBITS'(OFS_CNT);
  localparam logic [DBITS-1:0] ADDR_LIM = BASE + DBITS'(OFS_LIM);
  localparam logic [DBITS-1:0] ADDR_CTL = BASE + DBITS'(OFS_CTL);

  reg_sel_e         rsel;
  logic             wr_cnt;
  logic             wr_lim;
  logic             wr_ctl;
  logic             tick;
  logic             lim_hit;
  logic             lim_evt;
  logic [DBITS-1:0] cnt_q, cnt_d;
  logic [DBITS-1:0] lim_q, lim_d;
  logic             ready_q, ready_d;
  logic             ovr_q, ovr_d;
  logic [DBITS-1:0] ctl_rd;

  // Address decode
  always_comb begin
    rsel = REG_NONE;
    if (addr == ADDR_CNT) begin
      rsel = REG_CNT;
    end else if (addr == ADDR_LIM) begin
      rsel = REG_LIM;
    end else if (addr == ADDR_CTL) begin
      rsel = REG_CTL;
    end
  end

  assign sel    = (rsel != REG_NONE);
  assign wr_cnt = we && (rsel == REG_CNT);
  assign wr_lim = we && (rsel == REG_LIM);
  assign wr_ctl = we && (rsel == REG_CTL);

  timer_prescaler #(
    .DBITS  (DBITS),
    .TICKDIV(TICKDIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (wr_cnt || wr_lim),
    .tick (tick)
  );

  // A software write to TCNT/TLIM swallows a coincident tick, including its event
  assign lim_hit = (lim_q != '0) && (cnt_q == lim_q - DBITS'(1));
  assign lim_evt = tick && lim_hit && !wr_cnt && !wr_lim;

  always_comb begin
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    if (wr_cnt) begin
      cnt_d = wdata;
    end else if (wr_lim) begin
      lim_d = wdata;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = lim_hit ? '0 : cnt_q + DBITS'(1);
    end
    if (wr_ctl) begin
      ready_d = ready_q & wdata[CTL_READY];
      ovr_d   = ovr_q & wdata[CTL_OVR];
    end
    // Hardware set beats a same-cycle software clear so no event is lost
    if (lim_evt) begin
      ready_d = 1'b1;
      if (ready_q) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      lim_q   <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef BUS_TIMER_INTR_EN
  logic ie_q, ie_d;
  logic intr_q;

  assign ie_d = wr_ctl ? wdata[CTL_IE] : ie_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q   <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      intr_q <= ie_q & ready_q;
    end
  end

  assign intr = intr_q;

  always_comb begin
    ctl_rd            = '0;
    ctl_rd[CTL_READY] = ready_q;
    ctl_rd[CTL_OVR]   = ovr_q;
    ctl_rd[CTL_IE]    = ie_q;
  end
`else
  assign intr = 1'b0;

  always_comb begin
    ctl_rd            = '0;
    ctl_rd[CTL_READY] = ready_q;
    ctl_rd[CTL_OVR]   = ovr_q;
  end
`endif

  // Combinational read port; silent during writes and for foreign addresses
  always_comb begin
    rdata = '0;
    if (sel && !we) begin
      case (rsel)
        REG_CNT: rdata = cnt_q;
        REG_LIM: rdata = lim_q;
        REG_CTL: rdata = ctl_rd;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer with TICKDIV=4: a timed vector table plus
// hand sequences for reset behaviour, checked through an expected-value queue.
module tb_bus_timer;

  localparam logic [31:0] A_CNT = 32'hFFFFF100;
  localparam logic [31:0] A_LIM = 32'hFFFFF104;
  localparam logic [31:0] A_CTL = 32'hFFFFF108;
  localparam logic [31:0] A_UNM = 32'hFFFFF10C;

`ifdef BUS_TIMER_INTR_EN
  localparam logic [31:0] IEV = 32'h100;
  localparam logic        IR  = 1'b1;
`else
  localparam logic [31:0] IEV = 32'h0;
  localparam logic        IR  = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        sel;
  logic        intr;

  bus_timer #(
    .DBITS  (32),
    .BASE   (32'hFFFFF100),
    .TICKDIV(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .rdata(rdata),
    .sel  (sel),
    .intr (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] er;
    logic        es;
    logic        ei;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        sel;
    logic        intr;
    string       nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic add(input int t, input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic [31:0] er, input logic es, input logic ei, input string nm);
    vec_t v;
    v.t = t; v.addr = a; v.wdata = d; v.we = w; v.er = er; v.es = es; v.ei = ei; v.nm = nm;
    vecs.push_back(v);
  endtask

  // One bus cycle: drive at the falling edge, check 1 time unit later, wait for next fall
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input bit chk,
                      input logic [31:0] er, input logic es, input logic ei, input string nm);
    exp_t e;
    addr  = a;
    wdata = d;
    we    = w;
    if (chk) begin
      e.rdata = er; e.sel = es; e.intr = ei; e.nm = nm;
      sb.push_back(e);
    end
    #1;
    if (chk) begin
      e = sb.pop_front();
      vectors++;
      if (rdata !== e.rdata || sel !== e.sel || intr !== e.intr) begin
        miscompares++;
        $display("FAIL %s: got rdata=%h sel=%b intr=%b, want rdata=%h sel=%b intr=%b",
                 e.nm, rdata, sel, intr, e.rdata, e.sel, e.intr);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    reset = 1'b1;
    addr  = '0;
    wdata = '0;
    we    = 1'b0;

    // t = clock edges since reset release at the moment the vector is applied
    add(0,   A_CNT, 0, 0, 32'h0, 1, 0, "idle_cnt");
    add(1,   A_LIM, 0, 0, 32'h0, 1, 0, "idle_lim");
    add(2,   A_CTL, 0, 0, 32'h0, 1, 0, "idle_ctl");
    add(3,   A_CNT, 0, 0, 32'h0, 1, 0, "cnt_before_tick");
    add(4,   A_CNT, 0, 0, 32'h1, 1, 0, "cnt_first_tick");
    add(5,   A_LIM, 3, 1, 32'h0, 1, 0, "wr_lim3");
    add(6,   A_CNT, 0, 0, 32'h0, 1, 0, "lim_wr_zeroes_cnt");
    add(7,   A_UNM, 0, 0, 32'h0, 0, 0, "unmapped_read");
    add(8,   32'h0, 123, 1, 32'h0, 0, 0, "unmapped_write");
    add(10,  A_CNT, 0, 0, 32'h1, 1, 0, "cnt_seq1");
    add(14,  A_CNT, 0, 0, 32'h2, 1, 0, "cnt_seq2");
    add(17,  A_CTL, 0, 0, 32'h0, 1, 0, "ctl_before_event");
    add(18,  A_CNT, 0, 0, 32'h0, 1, 0, "cnt_wrap_at_lim");
    add(19,  A_CTL, 0, 0, 32'h1, 1, 0, "ready_set");
    add(29,  A_CTL, 0, 0, 32'h1, 1, 0, "ready_held");
    add(30,  A_CTL, 0, 0, 32'h3, 1, 0, "overrun_set");
    add(31,  A_CTL, 2, 1, 32'h0, 1, 0, "wr_ctl2");
    add(32,  A_CTL, 0, 0, 32'h2, 1, 0, "ready_cleared_ovr_kept");
    add(33,  A_CTL, 0, 1, 32'h0, 1, 0, "wr_ctl0");
    add(34,  A_CTL, 0, 0, 32'h0, 1, 0, "ctl_all_clear");
    add(42,  A_CTL, 0, 0, 32'h1, 1, 0, "ready_again");
    add(52,  A_CTL, 0, 0, 32'h1, 1, 0, "ready_before_race");
    add(53,  A_CTL, 0, 1, 32'h0, 1, 0, "clear_during_event");
    add(54,  A_CTL, 0, 0, 32'h3, 1, 0, "hw_set_wins");
    add(55,  A_LIM, 0, 1, 32'h0, 1, 0, "wr_lim0");
    add(56,  A_CTL, 0, 1, 32'h0, 1, 0, "wr_ctl0_b");
    add(57,  A_CNT, 32'hFFFFFFFF, 1, 32'h0, 1, 0, "wr_cnt_max");
    add(58,  A_CNT, 0, 0, 32'hFFFFFFFF, 1, 0, "cnt_max");
    add(61,  A_CNT, 0, 0, 32'hFFFFFFFF, 1, 0, "cnt_max_hold");
    add(62,  A_CNT, 0, 0, 32'h0, 1, 0, "free_run_wrap");
    add(63,  A_CTL, 0, 0, 32'h0, 1, 0, "no_flags_lim0");
    add(65,  A_CNT, 5, 1, 32'h0, 1, 0, "wr_cnt_on_tick");
    add(66,  A_CNT, 0, 0, 32'h5, 1, 0, "cnt_write_beats_tick");
    add(67,  A_CNT, 9, 1, 32'h0, 1, 0, "wr_cnt_mid_div");
    add(71,  A_CNT, 0, 0, 32'h9, 1, 0, "div_restarted");
    add(72,  A_CNT, 0, 0, 32'hA, 1, 0, "tick_after_restart");
    add(73,  A_LIM, 2, 1, 32'h0, 1, 0, "wr_lim2");
    add(74,  A_CNT, 32'hFFFFFFFE, 1, 32'h0, 1, 0, "wr_cnt_above_lim");
    add(78,  A_CNT, 0, 0, 32'hFFFFFFFE, 1, 0, "above_lim_hold");
    add(79,  A_CNT, 0, 0, 32'hFFFFFFFF, 1, 0, "above_lim_up");
    add(83,  A_CNT, 0, 0, 32'h0, 1, 0, "above_lim_wrap");
    add(86,  A_CTL, 0, 0, 32'h0, 1, 0, "no_event_at_wrap");
    add(87,  A_CNT, 0, 0, 32'h1, 1, 0, "cnt_at_lim_m1");
    add(90,  A_CTL, 0, 0, 32'h0, 1, 0, "ctl_before_late_event");
    add(91,  A_CTL, 0, 0, 32'h1, 1, 0, "late_event_ready");
    add(92,  A_CTL, 32'h100, 1, 32'h0, 1, 0, "wr_ie");
    add(93,  A_LIM, 1, 1, 32'h0, 1, 0, "wr_lim1");
    add(94,  A_CTL, 0, 0, IEV, 1, 0, "ie_readback");
    add(97,  A_CTL, 0, 0, IEV, 1, 0, "intr_idle");
    add(98,  A_CTL, 0, 0, IEV | 32'h1, 1, 0, "ready_intr_not_yet");
    add(99,  A_CTL, 32'h100, 1, 32'h0, 1, IR, "intr_rise");
    add(100, A_CTL, 0, 0, IEV, 1, IR, "intr_lags_clear");
    add(101, A_CTL, 0, 0, IEV, 1, 0, "intr_drop");

    @(negedge clk);
    step(A_CNT, 0, 0, 1, 32'h0, 1, 0, "rst_cnt");
    step(A_CTL, 0, 0, 1, 32'h0, 1, 0, "rst_ctl");
    reset = 1'b0;

    prev = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].t - prev - 1) step(32'h0, 0, 0, 0, 0, 0, 0, "idle");
      step(vecs[i].addr, vecs[i].wdata, vecs[i].we, 1, vecs[i].er, vecs[i].es, vecs[i].ei,
           vecs[i].nm);
      prev = vecs[i].t;
    end

    // Asynchronous reset in mid-count, then restart of the prescaler from zero
    step(A_CTL, 0, 1, 0, 0, 0, 0, "");
    step(A_LIM, 0, 1, 0, 0, 0, 0, "");
    step(A_CNT, 7, 1, 0, 0, 0, 0, "");
    step(A_CNT, 0, 0, 1, 32'h7, 1, 0, "pre_async_cnt");
    @(posedge clk);
    #2;
    reset = 1'b1;
    step(A_CNT, 0, 0, 1, 32'h0, 1, 0, "async_rst_cnt");
    step(A_LIM, 0, 0, 1, 32'h0, 1, 0, "async_rst_lim");
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(A_CNT, 0, 0, 1, 32'h0, 1, 0, "post_rst_hold");
    end
    step(A_CNT, 0, 0, 1, 32'h1, 1, 0, "post_rst_tick");

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
